// File: rtl/v_decode_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : v_decode_queue_if
//  Purpose  : Handshake bundle between the scalar issue port, the vector
//             decode queue and the vector dispatch logic.
//  Signals  : instr/instr_valid/instr_ready - producer side (instruction in)
//             dec_bus/dec_valid/dec_ready   - consumer side (control word out)
//  Modports : master - producer/consumer environment, slave - decode queue
//  Revision : 1.0  initial release
// ============================================================================
interface v_decode_queue_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [50:0] dec_bus;
    logic        dec_valid;
    logic        dec_ready;

    modport master (
        output instr, instr_valid, dec_ready,
        input  instr_ready, dec_bus, dec_valid
    );

    modport slave (
        input  instr, instr_valid, dec_ready,
        output instr_ready, dec_bus, dec_valid
    );
endinterface
`default_nettype wire

// File: rtl/v_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : v_decode_queue
//  Purpose  : RVV 1.0 decode stage with a DEPTH-entry control-word FIFO.
//             Instructions are decoded at enqueue; vset* instructions block
//             further issue until the downstream vconfig write commits.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             flush           - empties the queue and clears the vconfig wait
//             vcfg_done       - one-cycle pulse, vconfig write committed
//             bus (slave)     - instr/valid/ready in, dec_bus/valid/ready out
//             count           - current occupancy
//  Options  : V_DEC_BYPASS_EN - same-cycle pass-through when the queue is
//             empty, not waiting and both sides handshake
//  Revision : 1.0  initial release
// ============================================================================
module v_decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             vcfg_done,
    v_decode_queue_if.slave  bus,
    output logic [CNT_W-1:0] count
);

    localparam int               c_ptr_w   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;

    localparam logic [6:0] c_opc_v     = 7'b1010111;
    localparam logic [6:0] c_opc_load  = 7'b0000111;
    localparam logic [6:0] c_opc_store = 7'b0100111;
    localparam logic [2:0] c_f3_opivv  = 3'b000;
    localparam logic [2:0] c_f3_opmvv  = 3'b010;
    localparam logic [2:0] c_f3_opivi  = 3'b011;
    localparam logic [2:0] c_f3_opivx  = 3'b100;
    localparam logic [2:0] c_f3_opmvx  = 3'b110;
    localparam logic [2:0] c_f3_opcfg  = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_WAIT_CFG = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [50:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // ---------------------------------------------------------------- decode
    logic [6:0] w_opc;
    logic [2:0] w_funct3;
    logic [5:0] w_funct6;
    logic [1:0] w_mop;
    assign w_opc    = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct6 = bus.instr[31:26];
    assign w_mop    = bus.instr[27:26];

    logic       w_illegal, w_is_cfg, w_mul, w_vst, w_store, w_strided;
    logic [3:0] w_alu, w_lsu;
    logic [2:0] w_red, w_sldu;
    logic [1:0] w_sel_a, w_sel_b, w_sel_dest, w_wcode;

    always_comb begin
        w_illegal  = 1'b0;
        w_is_cfg   = 1'b0;
        w_mul      = 1'b0;
        w_vst      = 1'b0;
        w_alu      = 4'd0;
        w_lsu      = 4'd0;
        w_red      = 3'd0;
        w_sldu     = 3'd0;
        w_sel_a    = 2'd0;
        w_sel_b    = 2'd0;
        w_sel_dest = 2'd0;
        w_wcode    = 2'd0;
        w_store    = (w_opc == c_opc_store);
        w_strided  = (w_mop == 2'b10);
        case (w_opc)
            c_opc_v: begin
                case (w_funct3)
                    c_f3_opivv, c_f3_opivx, c_f3_opivi: begin
                        case (w_funct6)
                            6'b000000: w_alu = 4'd1;
                            6'b000010: w_alu = 4'd2;
                            6'b001001: w_alu = 4'd3;
                            6'b001010: w_alu = 4'd4;
                            6'b001011: w_alu = 4'd5;
                            6'b100101: w_alu = 4'd6;
                            6'b101000: w_alu = 4'd7;
                            6'b101001: w_alu = 4'd8;
                            6'b000101: w_alu = 4'd9;
                            6'b000111: w_alu = 4'd10;
                            6'b001110: if (w_funct3 != c_f3_opivv) w_sldu = 3'd1;
                            6'b001111: if (w_funct3 != c_f3_opivv) w_sldu = 3'd2;
                            6'b010111: if (w_funct3 == c_f3_opivx) w_sldu = 3'd5;
                            default: ;
                        endcase
                        w_illegal  = (w_alu == 4'd0) && (w_sldu == 3'd0);
                        w_sel_a    = (w_funct3 == c_f3_opivv) ? 2'd1 :
                                     (w_funct3 == c_f3_opivi) ? 2'd3 : 2'd2;
                        w_sel_b    = 2'd1;
                        w_sel_dest = 2'd1;
                    end
                    c_f3_opmvv: begin
                        w_mul = (w_funct6 == 6'b100101);
                        if (w_funct6 == 6'b000000) w_red = 3'd1;
                        if (w_funct6 == 6'b000111) w_red = 3'd2;
                        w_illegal  = !w_mul && (w_red == 3'd0);
                        w_sel_a    = 2'd1;
                        w_sel_b    = 2'd1;
                        w_sel_dest = 2'd1;
                    end
                    c_f3_opmvx: begin
                        w_mul = (w_funct6 == 6'b100101);
                        if (w_funct6 == 6'b001110) w_sldu = 3'd3;
                        if (w_funct6 == 6'b001111) w_sldu = 3'd4;
                        w_illegal  = !w_mul && (w_sldu == 3'd0);
                        w_sel_a    = 2'd2;
                        w_sel_b    = 2'd1;
                        w_sel_dest = 2'd1;
                    end
                    c_f3_opcfg: begin
                        w_is_cfg   = 1'b1;
                        w_sel_a    = 2'd2;
                        w_sel_b    = 2'd3;
                        w_sel_dest = 2'd2;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_load, c_opc_store: begin
                // width field occupies funct3's position for memory ops
                case (w_funct3)
                    3'b000:  w_wcode = 2'd0;
                    3'b101:  w_wcode = 2'd1;
                    3'b110:  w_wcode = 2'd2;
                    default: w_illegal = 1'b1;
                endcase
                if (w_mop != 2'b00 && !w_strided) w_illegal = 1'b1;
                w_lsu      = (w_store ? 4'd7 : 4'd1) + (w_strided ? 4'd3 : 4'd0)
                           + {2'b00, w_wcode};
                w_vst      = w_store;
                w_sel_a    = 2'd2;
                w_sel_b    = (w_store || w_strided) ? 2'd2 : 2'd0;
                w_sel_dest = 2'd1;
            end
            default: w_illegal = 1'b1;
        endcase
        // Register fields stay populated so the trap handler can report them.
        if (w_illegal) begin
            w_is_cfg   = 1'b0;
            w_mul      = 1'b0;
            w_vst      = 1'b0;
            w_alu      = 4'd0;
            w_lsu      = 4'd0;
            w_red      = 3'd0;
            w_sldu     = 3'd0;
            w_sel_a    = 2'd0;
            w_sel_b    = 2'd0;
            w_sel_dest = 2'd0;
        end
    end

    logic [50:0] w_dec;
    assign w_dec = {w_illegal, w_is_cfg, w_alu, w_mul, w_red, w_sldu, w_lsu, w_vst,
                    w_sel_a, w_sel_b, w_sel_dest, bus.instr[11:7], bus.instr[19:15],
                    bus.instr[24:20], bus.instr[30:20], 1'b0};

    // ----------------------------------------------------------- handshakes
    logic        w_ready, w_fifo_valid, w_bypass, w_push, w_pop, w_cfg_issue;
    logic        w_dec_valid;
    logic [50:0] w_dec_bus;

    assign w_ready      = (r_count < c_depth) && !flush;
    assign w_fifo_valid = (r_count != '0) && (r_state == ST_RUN);
`ifdef V_DEC_BYPASS_EN
    assign w_bypass     = (r_count == '0) && (r_state == ST_RUN) && bus.instr_valid
                          && bus.dec_ready && !flush;
`else
    assign w_bypass     = 1'b0;
`endif
    assign w_dec_valid  = w_bypass || w_fifo_valid;
    assign w_dec_bus    = w_bypass ? w_dec : r_mem[r_rd_ptr];
    assign w_push       = bus.instr_valid && w_ready && !w_bypass;
    assign w_pop        = w_fifo_valid && bus.dec_ready;
    assign w_cfg_issue  = w_dec_valid && bus.dec_ready && w_dec_bus[49];

    assign bus.instr_ready = w_ready;
    assign bus.dec_valid   = w_dec_valid;
    assign bus.dec_bus     = w_dec_bus;
    assign count           = r_count;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_cfg_issue) w_state_nxt = ST_WAIT_CFG;
            ST_WAIT_CFG: if (vcfg_done)   w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
        if (flush) w_state_nxt = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // ----------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/v_decode_queue.md
# v_decode_queue

Buffered, parametrised vector decode stage between the scalar core's vector-instruction issue port and the vector issue/dispatch logic. Decodes each 32-bit RVV 1.0 instruction at enqueue into a packed control word and buffers up to DEPTH words in a FIFO. Both sides use a valid/ready handshake. Serialises `vset*` configuration instructions against downstream completion and flags illegal encodings.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, $clog2(DEPTH)+1: width of the occupancy count.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: synchronous flush; empties FIFO and clears the vconfig wait.
- `instr` input 32: instruction word, valid with `instr_valid`.
- `instr_valid` input 1: producer offers `instr`.
- `instr_ready` output 1: FIFO can accept; equals (count < DEPTH) && !flush.
- `dec_bus` output 51: head control word, MSB to LSB:
  - `illegal`[50], `is_vconfig`[49], `v_alu_op`[48:45], `is_mul`[44], `v_red_op`[43:41]
  - `v_sldu_op`[40:38], `v_lsu_op`[37:34], `is_vstype`[33], `v_op_sel_A`[32:31], `v_op_sel_B`[30:29]
  - `v_sel_dest`[28:27], `vd`[26:22], `vs1`[21:17], `vs2`[16:12], `zimm`[11:1], reserved[0]=0
- `dec_valid` output 1: `dec_bus` holds a valid entry and issue is not blocked.
- `dec_ready` input 1: consumer accepts head when `dec_valid`.
- `vcfg_done` input 1: one-cycle pulse; the downstream vconfig write has committed.
- `count` output CNT_W: current FIFO occupancy.

## Operation
- **Opcodes.**
  - OP-V = 7'b1010111.
  - Load = 7'b0000111.
  - Store = 7'b0100111.
  - Any other opcode is illegal.
- **funct3.** OPIVV 000, OPMVV 010, OPIVI 011, OPIVX 100, OPMVX 110, OPCFG 111.
- **`v_alu_op`.** Legal with OPIVV/OPIVX/OPIVI. Code (funct6):
  - 1 vadd (000000), 2 vsub (000010), 3 vand (001001), 4 vor (001010), 5 vxor (001011)
  - 6 vsll (100101), 7 vsrl (101000), 8 vsra (101001), 9 vmin (000101), 10 vmax (000111)
- **`is_mul`.** Set for funct6 100101 with OPMVV/OPMVX.
- **`v_red_op`.** OPMVV only: 1 vredsum (000000), 2 vredmax (000111).
- **`v_sldu_op`.**
  - 1 vslideup (001110) and 2 vslidedown (001111), OPIVX/OPIVI.
  - 3 vslide1up and 4 vslide1down, same funct6, OPMVX.
  - 5 vmv (010111), OPIVX.
- **`v_lsu_op`.** Decoded from mop = instr[27:26] (00 unit, 10 strided) and width = instr[14:12] (000/101/110 = 8/16/32).
  - Loads: 1..3 vle8/16/32, 4..6 vlse8/16/32.
  - Stores: 7..9 vse8/16/32, 10..12 vsse8/16/32.
  - `is_vstype` = 1 for stores.
- **Operand A select.** 1 for VV; 2 for VX, OPCFG, load and store; 3 for VI.
- **Operand B select.** 1 for OPI*/OPM*; 2 for store or strided load; 3 for OPCFG.
- **Destination select.** 1 for vector writes (load, store, OPI*, OPM*); 2 for OPCFG (writes rd).
- **Field extraction.** vd = [11:7], vs1/imm = [19:15], vs2 = [24:20], zimm = [30:20].
- **Illegal.** `illegal` = 1 for an unknown opcode, any unmatched OP-V funct3/funct6 pair, or an unsupported lsu mop/width.
  - All op fields of an illegal entry are 0.
  - The entry is still enqueued; the consumer traps.
- **Enqueue.** Occurs when `instr_valid && instr_ready`. Decode is combinational on `instr`, registered into the tail slot.
- **Dequeue.** Occurs when `dec_valid && dec_ready`; the head pointer advances.
- **Pointers.** log2(DEPTH) bits, wrap naturally.
- **State machine** (2 states):
  - RUN: a dequeue with head `is_vconfig`=1 moves to WAIT_CFG.
  - WAIT_CFG: `dec_valid` is forced 0 and the head is held; `vcfg_done` returns to RUN.
  - A `vcfg_done` pulse in RUN is ignored.
- **Full FIFO.** `instr_ready` = 0.
- **Simultaneous enqueue and dequeue when full.** Not allowed; ready is based on registered count.
- **Simultaneous enqueue and dequeue when empty.** Behaviour is governed by the bypass configuration.
- **Flush and reset.**
  - `flush` has priority over enqueue and dequeue in the same cycle.
  - On flush, `count` goes to 0, pointers to 0, state to RUN.
  - `rst` does the same plus clears storage, whether or not an operation is in progress.

## Timing
- **Reset values.**
  - `dec_bus` = 0, `dec_valid` = 0, `count` = 0, state RUN.
  - `instr_ready` = 1 on the first cycle after reset deassertion.
- **Latency.** Enqueue at edge N makes `dec_valid` = 1 from cycle N+1 (non-bypass).
- **Throughput.** One instruction per cycle on each side.
- **Stable output.** `dec_bus` holds stable while `dec_valid && !dec_ready`.
- **WAIT_CFG timing.**
  - Entered on the edge of the vconfig dequeue.
  - `vcfg_done` at edge M makes `dec_valid` possible from cycle M+1.

## Configuration
- **`V_DEC_BYPASS_EN` defined.** When count = 0, state RUN, `instr_valid` and `dec_ready` are all true, the decoded word is driven directly on `dec_bus` and `dec_valid` in the same cycle. Nothing is stored; a vconfig still enters WAIT_CFG.
- **Not defined.** Every instruction passes through the FIFO, with minimum latency of 1 cycle.

## Test plan
- Reset, then enqueue 0x022081D7 (vadd.vv v3,v1,v2) -> next cycle `dec_valid` = 1, alu = 1, sel_A = 1, sel_B = 1, dest = 1, vd = 3, vs1 = 1, vs2 = 2, illegal = 0.
- Hold `dec_ready` = 0 and push DEPTH+1 instructions -> `count` = DEPTH and `instr_ready` = 0. Release -> order preserved across pointer wrap.
- Enqueue vsetvli (funct3 111), then vadd -> vadd is held with `dec_valid` = 0 until `vcfg_done` pulses, and is valid the cycle after.
- Enqueue opcode 0x33 and OP-V funct6 111111 -> both entries appear with `illegal` = 1 and all op fields 0.
- Assert `flush` while 3 entries are queued in WAIT_CFG -> next cycle `count` = 0, `dec_valid` = 0, state RUN. Next instruction decodes normally.
- Check vlse32 (mop 10, width 110) -> `v_lsu_op` = 6 and sel_B = 2. Check vse8 -> `v_lsu_op` = 7 and `is_vstype` = 1. With `V_DEC_BYPASS_EN`, an empty-queue vadd gives same-cycle `dec_valid`.
